// File: rtl/encoder_4x2_seq.sv
// rtl/encoder_4x2_seq.sv - sequential multi-hot to binary encoder with valid/ready handshakes
//
// Accepts a request vector on the input handshake and latches it into a
// pending register. Then emits the binary index of every set bit, one code
// per output handshake. out_last flags the final pending bit. An all-zero
// vector is consumed without output and reported by a one-cycle zero_err pulse.
//
// Optional feature macro: ENCODER_ROUND_ROBIN_EN
//   defined   : round-robin selection. The search starts one past the last
//               served code, and that pointer persists across vectors.
//   undefined : fixed priority. The lowest set index wins and no pointer is built.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   enable     in   low freezes all state and forces in_ready/out_valid to 0
//   in_req     in   [N] request vector, bit i requests code i
//   in_valid   in   in_req is valid
//   in_ready   out  block can accept a vector
//   out_code   out  [W] binary index of the bit being served
//   out_valid  out  out_code is valid
//   out_ready  in   consumer accepts out_code
//   out_last   out  current code is the final pending bit
//   zero_err   out  one-cycle pulse after an all-zero vector is accepted
module encoder_4x2_seq #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enable,
   input  logic [N-1:0] in_req,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_code,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_last,
   output logic         zero_err
);

   typedef enum logic {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } state_t;

   state_t       state;
   state_t       state_next;
   logic [N-1:0] pending;
   logic [N-1:0] pending_clr;
   logic [W-1:0] sel_code;
   logic [W-1:0] search_base;
   logic         last_bit;
   logic         req_zero;
   logic         in_fire;
   logic         out_fire;
   logic         zero_err_q;

   assign req_zero = (in_req == '0);
   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   // Exactly one bit left when pending is non-zero and clearing its lowest
   // set bit leaves nothing.
   assign last_bit = (pending != '0) && ((pending & (pending - N'(1))) == '0);

   // Served bit removed from the pending set.
   assign pending_clr = pending & ~(N'(1) << sel_code);

`ifdef ENCODER_ROUND_ROBIN_EN
   // Last served code. The reset value N-1 makes the first search start at 0.
   // N is a power of two, so the W-bit wrap of ptr+1 is the mod-N wrap.
   logic [W-1:0] ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '1;
      end else if (out_fire) begin
         ptr <= sel_code;
      end
   end

   assign search_base = ptr + W'(1);
`else
   assign search_base = '0;
`endif

   // Scan all N positions starting at search_base and wrapping. The first set
   // bit found is the winner. With an empty pending set the code defaults to 0.
   always_comb begin
      logic [W-1:0] idx;
      logic         found;
      sel_code = '0;
      found    = 1'b0;
      idx      = '0;
      for (int i = 0; i < N; i++) begin
         idx = search_base + W'(i);
         if (!found && pending[idx]) begin
            sel_code = idx;
            found    = 1'b1;
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else if (enable) begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (in_fire && !req_zero) begin
               state_next = SERVE;
            end
         end
         SERVE: begin
            if (out_fire && last_bit) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Pending set. The input and output handshakes never fire in the same
   // cycle because in_ready and out_valid belong to different states.
   // Both fire terms already include enable, so the register holds while frozen.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
      end else if (in_fire && !req_zero) begin
         pending <= in_req;
      end else if (out_fire) begin
         pending <= pending_clr;
      end
   end

   // A zero vector is reported on the cycle after it is accepted and for that
   // cycle only. The pulse is not held through a freeze.
   always_ff @(posedge clk) begin
      if (rst) begin
         zero_err_q <= 1'b0;
      end else begin
         zero_err_q <= in_fire & req_zero;
      end
   end

   // Output logic. out_code and out_last come only from registered state.
   // rst gates in_ready so nothing is accepted during the reset cycle.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE:    in_ready  = enable & ~rst;
         SERVE:   out_valid = enable;
         default: ;
      endcase
      out_code = sel_code;
      out_last = last_bit;
      zero_err = zero_err_q;
   end

endmodule

// File: tb/tb_encoder_4x2_seq.sv
// tb/tb_encoder_4x2_seq.sv - self-checking bench for encoder_4x2_seq
module tb_encoder_4x2_seq;

   localparam int N = 4;
   localparam int W = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         enable;
   logic [N-1:0] in_req;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] out_code;
   logic         out_valid;
   logic         out_ready;
   logic         out_last;
   logic         zero_err;

   int           n_checks = 0;
   int           n_fail   = 0;
   logic [W:0]   sb[$];
   logic [W:0]   exp_e;

   always #5 clk = ~clk;

   encoder_4x2_seq #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .in_req    (in_req),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_code  (out_code),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .zero_err  (zero_err)
   );

   task apply_reset;
      @(negedge clk);
      rst = 1'b1; enable = 1'b1; in_valid = 1'b0; in_req = '0; out_ready = 1'b0;
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   task test_reset;
      @(negedge clk);
      rst = 1'b1; enable = 1'b1; in_valid = 1'b0; in_req = '0; out_ready = 1'b0;
      @(negedge clk); #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      n_checks++; if (out_code !== 2'd0) begin n_fail++; $display("FAIL rst_out_code: got %0d want 0", out_code); end
      n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_out_last: got %b want 0", out_last); end
      n_checks++; if (zero_err !== 1'b0) begin n_fail++; $display("FAIL rst_zero_err: got %b want 0", zero_err); end
      rst = 1'b0; #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_in_ready: got %b want 1", in_ready); end
   endtask

   task test_fixed_priority;
      apply_reset;
      in_req = 4'b1011; in_valid = 1'b1; out_ready = 1'b1;
      sb.push_back({1'b0, 2'd0});
      sb.push_back({1'b0, 2'd1});
      sb.push_back({1'b1, 2'd3});
      @(negedge clk);
      in_valid = 1'b0; #1;
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fp_valid[%0d]: got %b want 1", i, out_valid); end
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++; $display("FAIL fp_sb_underflow[%0d]: got empty want entry", i);
         end else begin
            exp_e = sb.pop_front();
            if ({out_last, out_code} !== exp_e) begin
               n_fail++; $display("FAIL fp_code[%0d]: got last=%b code=%0d want last=%b code=%0d", i, out_last, out_code, exp_e[W], exp_e[W-1:0]);
            end
         end
         @(negedge clk); #1;
      end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fp_in_ready_after: got %b want 1", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fp_valid_after: got %b want 0", out_valid); end
   endtask

   task test_backpressure;
      apply_reset;
      in_req = 4'b0110; in_valid = 1'b1; out_ready = 1'b0;
      sb.push_back({1'b0, 2'd1});
      sb.push_back({1'b1, 2'd2});
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         out_ready = (i >= 3);
         #1;
         n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++; $display("FAIL bp_sb_underflow[%0d]: got empty want entry", i);
         end else begin
            exp_e = sb[0];
            if ({out_last, out_code} !== exp_e) begin
               n_fail++; $display("FAIL bp_code[%0d]: got last=%b code=%0d want last=%b code=%0d", i, out_last, out_code, exp_e[W], exp_e[W-1:0]);
            end
            if (out_ready) void'(sb.pop_front());
         end
         @(negedge clk);
      end
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_after: got %b want 1", in_ready); end
   endtask

   task test_zero_vector;
      int pulses;
      pulses = 0;
      apply_reset;
      in_req = 4'b0000; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; #1;
      n_checks++; if (zero_err !== 1'b1) begin n_fail++; $display("FAIL zv_pulse: got %b want 1", zero_err); end
      for (int i = 0; i < 4; i++) begin
         if (zero_err === 1'b1) pulses++;
         n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL zv_valid[%0d]: got %b want 0", i, out_valid); end
         n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL zv_in_ready[%0d]: got %b want 1", i, in_ready); end
         @(negedge clk); #1;
      end
      n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL zv_pulse_count: got %0d want 1", pulses); end
   endtask

   task test_reset_mid;
      apply_reset;
      in_req = 4'b1111; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; #1;
      n_checks++; if ({out_valid, out_code} !== {1'b1, 2'd0}) begin n_fail++; $display("FAIL rm_first: got valid=%b code=%0d want valid=1 code=0", out_valid, out_code); end
      @(negedge clk);
      rst = 1'b1; #1;
      n_checks++; if (out_code !== 2'd1) begin n_fail++; $display("FAIL rm_second: got %0d want 1", out_code); end
      @(negedge clk);
      rst = 1'b0; #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid: got %b want 0", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rm_in_ready: got %b want 1", in_ready); end
      n_checks++; if (out_code !== 2'd0) begin n_fail++; $display("FAIL rm_code: got %0d want 0", out_code); end
   endtask

   task test_enable_freeze;
      apply_reset;
      in_req = 4'b1100; in_valid = 1'b1; out_ready = 1'b1;
      sb.push_back({1'b0, 2'd2});
      sb.push_back({1'b1, 2'd3});
      @(negedge clk);
      in_valid = 1'b0; #1;
      n_checks++; if ({out_valid, out_code} !== {1'b1, 2'd2}) begin n_fail++; $display("FAIL ef_pre: got valid=%b code=%0d want valid=1 code=2", out_valid, out_code); end
      enable = 1'b0; #1;
      for (int i = 0; i < 2; i++) begin
         n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ef_frozen_valid[%0d]: got %b want 0", i, out_valid); end
         n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ef_frozen_in_ready[%0d]: got %b want 0", i, in_ready); end
         @(negedge clk); #1;
      end
      enable = 1'b1; #1;
      for (int i = 0; i < 2; i++) begin
         n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ef_valid[%0d]: got %b want 1", i, out_valid); end
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++; $display("FAIL ef_sb_underflow[%0d]: got empty want entry", i);
         end else begin
            exp_e = sb.pop_front();
            if ({out_last, out_code} !== exp_e) begin
               n_fail++; $display("FAIL ef_code[%0d]: got last=%b code=%0d want last=%b code=%0d", i, out_last, out_code, exp_e[W], exp_e[W-1:0]);
            end
         end
         @(negedge clk); #1;
      end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ef_in_ready_after: got %b want 1", in_ready); end
   endtask

   task test_back_to_back;
      int acc;
      int done;
      acc  = 0;
      done = -1;
      apply_reset;
      out_ready = 1'b1;
      sb.push_back({1'b0, 2'd1});
      sb.push_back({1'b1, 2'd2});
`ifdef ENCODER_ROUND_ROBIN_EN
      sb.push_back({1'b0, 2'd3});
      sb.push_back({1'b0, 2'd0});
      sb.push_back({1'b1, 2'd1});
`else
      sb.push_back({1'b0, 2'd0});
      sb.push_back({1'b0, 2'd1});
      sb.push_back({1'b1, 2'd3});
`endif
      for (int i = 0; i < 20; i++) begin
         in_valid = (acc < 2);
         in_req   = (acc == 0) ? 4'b0110 : 4'b1011;
         #1;
         if (in_valid && in_ready) acc++;
         if (out_valid && out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++; $display("FAIL bb_sb_underflow[%0d]: got empty want entry", i);
            end else begin
               exp_e = sb.pop_front();
               if ({out_last, out_code} !== exp_e) begin
                  n_fail++; $display("FAIL bb_code[%0d]: got last=%b code=%0d want last=%b code=%0d", i, out_last, out_code, exp_e[W], exp_e[W-1:0]);
               end
            end
         end
         if (sb.size() == 0) begin
            done = i;
            break;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      n_checks++; if (done != 6) begin n_fail++; $display("FAIL bb_cycles: got %0d want 6", done); end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1);
   end

   initial begin
      test_reset;
      test_fixed_priority;
      test_backpressure;
      test_zero_vector;
      test_reset_mid;
      test_enable_freeze;
      test_back_to_back;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
